// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The overflow signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrowin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] difference;
  logic             borrowout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  // start is a request pulse/level: it is accepted on a rising edge only while
  // the block is idle or done; busy and done are status, not a ready signal.
  modport master (
    output start, a, b, borrowin,
    input  busy, done, difference, borrowout
`ifdef SERIAL_SUB_OVERFLOW_EN
    , input overflow
`endif
  );

  modport slave (
    input  start, a, b, borrowin,
    output busy, done, difference, borrowout
`ifdef SERIAL_SUB_OVERFLOW_EN
    , output overflow
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrowin, LSB first, one bit per clock with a single borrow flop.
// Optional signed overflow output enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             load, last, d, borrow_nxt;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             a_msb, b_msb;
`endif

  assign load       = bus.start && (state == IDLE || state == DONE);
  assign last       = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign d          = a_sr[0] ^ b_sr[0] ^ borrow;
  assign borrow_nxt = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & borrow);
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      SHIFT:   bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr           <= '0;
      b_sr           <= '0;
      diff_sr        <= '0;
      borrow         <= 1'b0;
      cnt            <= '0;
      bus.difference <= '0;
      bus.borrowout  <= 1'b0;
    end else if (load) begin
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      borrow <= bus.borrowin;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      diff_sr <= {d, diff_sr[WIDTH-1:1]};
      borrow  <= borrow_nxt;
      cnt     <= cnt + CW'(1);
      // The final bit goes straight into the result, so diff_sr is never exposed.
      if (last) begin
        bus.difference <= {d, diff_sr[WIDTH-1:1]};
        bus.borrowout  <= borrow_nxt;
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb        <= 1'b0;
      b_msb        <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (load) begin
      a_msb <= bus.a[WIDTH-1];
      b_msb <= bus.b[WIDTH-1];
    end else if (last) begin
      // d is the MSB of the difference on the completing edge.
      bus.overflow <= (a_msb ^ b_msb) & (a_msb ^ d);
    end
  end
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: driver tasks push expected results into a
// queue that a negedge monitor pops whenever done is presented.
module tb_serial_subtractor;
  localparam int W = 32;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Packed expectation: {overflow, borrowout, difference}.
  logic [W+1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        check("difference", 64'(bus.difference), 64'(e[W-1:0]));
        check("borrowout", 64'(bus.borrowout), 64'(e[W]));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check("overflow", 64'(bus.overflow), 64'(e[W+1]));
`endif
        check("busy_in_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  task automatic start_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin,
                          input logic push, input logic [W-1:0] ed, input logic eb,
                          input logic eo);
    @(negedge clk);
    bus.a        = ia;
    bus.b        = ib;
    bus.borrowin = ibin;
    bus.start    = 1'b1;
    if (push) exp_q.push_back({eo, eb, ed});
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.borrowin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(output int busy_n, output bit seen);
    busy_n = 0;
    seen   = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
      else if (bus.busy) busy_n++;
    end
  endtask

  int busy_n;
  bit seen;

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.borrowin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_difference", 64'(bus.difference), 64'd0);
    check("rst_borrowout", 64'(bus.borrowout), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;

    start_op(32'd5, 32'd3, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
    wait_done(busy_n, seen);
    check("done_seen_5m3", 64'(seen), 64'd1);
    check("busy_cycles_5m3", 64'(busy_n), 64'd32);

    start_op(32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    wait_done(busy_n, seen);
    check("done_seen_min", 64'(seen), 64'd1);

    start_op(32'd7, 32'd2, 1'b0, 1'b1, 32'h0000_0005, 1'b0, 1'b0);
    wait_done(busy_n, seen);
    check("done_seen_7m2", 64'(seen), 64'd1);

    start_op(32'd3, 32'd5, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
    wait_done(busy_n, seen);
    check("done_seen_3m5", 64'(seen), 64'd1);

    start_op(32'd0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done(busy_n, seen);
    check("done_seen_borrowin", 64'(seen), 64'd1);

    // Reset in the middle of SHIFT: outputs clear without waiting for a clock edge.
    start_op(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_busy", 64'(bus.busy), 64'd0);
    check("async_done", 64'(bus.done), 64'd0);
    check("async_difference", 64'(bus.difference), 64'd0);
    check("async_borrowout", 64'(bus.borrowout), 64'd0);
    check("async_state", 64'(dbg_state), 64'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("async_overflow", 64'(bus.overflow), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_reset_done", 64'(bus.done), 64'd0);
    end
    check("post_reset_busy", 64'(bus.busy), 64'd0);

    start_op(32'd2, 32'd1, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b0);
    wait_done(busy_n, seen);
    check("done_seen_2m1", 64'(seen), 64'd1);
    check("busy_cycles_2m1", 64'(busy_n), 64'd32);

    // A start pulse during SHIFT must be ignored.
    start_op(32'd10, 32'd4, 1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    // Hold start through DONE: the next op starts with no IDLE cycle.
    @(negedge clk);
    bus.a        = 32'd9;
    bus.b        = 32'd9;
    bus.borrowin = 1'b0;
    bus.start    = 1'b1;
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0000});
    wait_done(busy_n, seen);
    check("done_seen_ignored", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    check("b2b_state", 64'(dbg_state), 64'd1);
    check("b2b_busy", 64'(bus.busy), 64'd1);
    wait_done(busy_n, seen);
    check("done_seen_b2b", 64'(seen), 64'd1);
    check("busy_cycles_b2b", 64'(busy_n), 64'd32);

    repeat (3) @(negedge clk);
    check("final_state_idle", 64'(dbg_state), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
